// File: rtl/tap_chain_pkg.sv
// Shared definitions for the tap chain: tap-select width helper and the
// sentinel index used when tap_sel points past the last stage.
package tap_chain_pkg;

    localparam int TAP_NONE = -1;

    // A one-stage select port would otherwise collapse to zero bits.
    function automatic int tap_w(input int depth);
        return (depth > 2) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/tap_chain_stage.sv
// One elastic register slice: loads the upstream word when the downstream
// path can make room, and drops its valid bit on flush while keeping data.
module tap_chain_stage #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RESETN,
    input  logic             flush,
    input  logic             load,
    input  logic             up_valid,
    input  logic [WIDTH-1:0] up_data,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= up_valid;
            if (up_valid) begin
                data <= up_data;
            end
        end
    end

endmodule

// File: rtl/tap_chain_pipeline.sv
// Elastic delay line of DEPTH stages with valid/ready, flush, a runtime
// tap onto any stage and a snapshot register fed from that tap.
module tap_chain_pipeline
    import tap_chain_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int TAP_W = tap_w(DEPTH)
) (
    input  logic             CLK,
    input  logic             RESETN,
    input  logic             I_valid,
    output logic             I_ready,
    input  logic [WIDTH-1:0] I_data,
    output logic             O_valid,
    input  logic             O_ready,
    output logic [WIDTH-1:0] O_data,
    input  logic             flush,
    input  logic [TAP_W-1:0] tap_sel,
    output logic             tap_valid,
    output logic [WIDTH-1:0] tap_data,
    input  logic             snap_strobe,
    output logic             snap_valid,
    output logic [WIDTH-1:0] snap_data
);

    typedef struct packed {
        logic             v;
        logic [WIDTH-1:0] d;
    } stage_t;

    logic [DEPTH-1:0] vld_p;
    logic [WIDTH-1:0] dat_p [DEPTH];
    logic [DEPTH-1:0] rdy;
    logic             in_acc;
    int               sel_idx;
    stage_t           tap_st;

    // A stage can load when the consumer takes a word or any bubble sits at
    // or downstream of it; written flat so no signal feeds back on itself.
    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            rdy[k] = O_ready;
            for (int j = k; j < DEPTH; j++) begin
                if (!vld_p[j]) begin
                    rdy[k] = 1'b1;
                end
            end
        end
    end

    assign I_ready = rdy[0] & ~flush;
    assign in_acc  = I_valid & I_ready;

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        logic             up_v;
        logic [WIDTH-1:0] up_d;

        if (k == 0) begin : g_head
            assign up_v = in_acc;
            assign up_d = I_data;
        end else begin : g_body
            assign up_v = vld_p[k-1];
            assign up_d = dat_p[k-1];
        end

        tap_chain_stage #(.WIDTH(WIDTH)) u_stage (
            .CLK      (CLK),
            .RESETN   (RESETN),
            .flush    (flush),
            .load     (rdy[k]),
            .up_valid (up_v),
            .up_data  (up_d),
            .valid    (vld_p[k]),
            .data     (dat_p[k])
        );
    end

    assign O_valid = vld_p[DEPTH-1];
    assign O_data  = dat_p[DEPTH-1];

    // Selects past the last stage resolve to TAP_NONE and read as zero.
    assign sel_idx = (int'(tap_sel) < DEPTH) ? int'(tap_sel) : TAP_NONE;

    always_comb begin
        tap_st = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (sel_idx == k) begin
                tap_st.v = vld_p[k];
                tap_st.d = dat_p[k];
            end
        end
    end

    assign tap_valid = tap_st.v;
    assign tap_data  = tap_st.d;

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            snap_valid <= 1'b0;
            snap_data  <= '0;
        end else if (snap_strobe && !flush) begin
            snap_valid <= tap_st.v;
            snap_data  <= tap_st.d;
        end
    end

endmodule

// File: tb/tb_tap_chain_pipeline.sv
// Bench for tap_chain_pipeline: scoreboard on the stream port, tap table,
// flush, snapshot and mid-stream reset sequences.
module tb_tap_chain_pipeline;

    localparam int W = 8;
    localparam int D = 4;

    logic         CLK = 1'b0;
    logic         RESETN;
    logic         I_valid, I_ready, O_valid, O_ready, flush;
    logic [W-1:0] I_data, O_data, tap_data, snap_data;
    logic [1:0]   tap_sel;
    logic         tap_valid, snap_strobe, snap_valid;

    logic         c2_valid, c2_ready, c2_o_valid, c2_o_ready, c2_flush;
    logic [W-1:0] c2_data, c2_o_data, c2_tap_data, c2_snap_data;
    logic [2:0]   c2_tap_sel;
    logic         c2_tap_valid, c2_snap_strobe, c2_snap_valid;

    tap_chain_pipeline #(.WIDTH(W), .DEPTH(D)) dut (
        .CLK(CLK), .RESETN(RESETN),
        .I_valid(I_valid), .I_ready(I_ready), .I_data(I_data),
        .O_valid(O_valid), .O_ready(O_ready), .O_data(O_data),
        .flush(flush), .tap_sel(tap_sel), .tap_valid(tap_valid), .tap_data(tap_data),
        .snap_strobe(snap_strobe), .snap_valid(snap_valid), .snap_data(snap_data)
    );

    tap_chain_pipeline #(.WIDTH(W), .DEPTH(5)) dut5 (
        .CLK(CLK), .RESETN(RESETN),
        .I_valid(c2_valid), .I_ready(c2_ready), .I_data(c2_data),
        .O_valid(c2_o_valid), .O_ready(c2_o_ready), .O_data(c2_o_data),
        .flush(c2_flush), .tap_sel(c2_tap_sel), .tap_valid(c2_tap_valid), .tap_data(c2_tap_data),
        .snap_strobe(c2_snap_strobe), .snap_valid(c2_snap_valid), .snap_data(c2_snap_data)
    );

    always #5 CLK = ~CLK;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        bit         big;
        int         sel;
        logic       ev;
        logic [7:0] ed;
    } tap_vec_t;

    tap_vec_t   tv [12];
    logic [7:0] exp_q [$];
    int n_tests = 0, n_fail = 0;
    int cyc = 0, n_out = 0, first_out = -1, last_out = -1;
    bit last_acc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Sample just before the edge, update the scoreboard, then advance one cycle.
    task automatic step();
        logic [7:0] e;
        #1;
        chk("i_ready", {31'd0, I_ready}, {31'd0, (!flush && (O_ready || exp_q.size() < D))});
        if (O_valid && O_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_out", {24'd0, O_data}, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                chk("o_data", {24'd0, O_data}, {24'd0, e});
            end
            n_out++;
            if (first_out < 0) first_out = cyc;
            last_out = cyc;
        end
        if (flush) exp_q.delete();
        last_acc = I_valid && I_ready;
        if (last_acc) exp_q.push_back(I_data);
        @(posedge CLK);
        @(negedge CLK);
        cyc++;
    endtask

    task automatic drain(input string name);
        I_valid = 1'b0;
        O_ready = 1'b1;
        for (int i = 0; i < 40 && exp_q.size() > 0; i++) step();
        chk(name, exp_q.size(), 0);
    endtask

    initial begin
        int idx, acc0, out0;

        tv[0]  = '{0, 0, 1'b1, 8'hA3};
        tv[1]  = '{0, 1, 1'b1, 8'hA2};
        tv[2]  = '{0, 2, 1'b1, 8'hA1};
        tv[3]  = '{0, 3, 1'b1, 8'hA0};
        tv[4]  = '{1, 0, 1'b1, 8'hB4};
        tv[5]  = '{1, 1, 1'b1, 8'hB3};
        tv[6]  = '{1, 2, 1'b1, 8'hB2};
        tv[7]  = '{1, 3, 1'b1, 8'hB1};
        tv[8]  = '{1, 4, 1'b1, 8'hB0};
        tv[9]  = '{1, 5, 1'b0, 8'h00};
        tv[10] = '{1, 6, 1'b0, 8'h00};
        tv[11] = '{1, 7, 1'b0, 8'h00};

        RESETN = 1'b0; I_valid = 1'b0; I_data = '0; O_ready = 1'b0; flush = 1'b0;
        tap_sel = '0; snap_strobe = 1'b0;
        c2_valid = 1'b0; c2_data = '0; c2_o_ready = 1'b0; c2_flush = 1'b0;
        c2_tap_sel = '0; c2_snap_strobe = 1'b0;

        // Reset state
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        #1;
        chk("rst_o_valid", {31'd0, O_valid}, 0);
        chk("rst_i_ready", {31'd0, I_ready}, 1);
        chk("rst_snap_valid", {31'd0, snap_valid}, 0);
        chk("rst_o_data", {24'd0, O_data}, 0);
        for (int s = 0; s < D; s++) begin
            tap_sel = 2'(s);
            #1;
            chk("rst_tap_data", {24'd0, tap_data}, 0);
            chk("rst_tap_valid", {31'd0, tap_valid}, 0);
        end
        RESETN = 1'b1;
        @(negedge CLK);

        // Back-to-back stream: latency DEPTH, one word per cycle
        O_ready = 1'b1;
        out0 = n_out; first_out = -1; acc0 = cyc;
        for (int i = 0; i < 16; i++) begin
            I_valid = 1'b1;
            I_data  = 8'(i + 1);
            step();
        end
        drain("stream_drain");
        chk("stream_latency", first_out - acc0, D);
        chk("stream_count", n_out - out0, 16);
        chk("stream_rate", last_out - first_out, 15);

        // Backpressure: only DEPTH words fit, then release without loss
        O_ready = 1'b0;
        idx = 0; out0 = n_out;
        for (int i = 0; i < 6; i++) begin
            I_valid = 1'b1;
            I_data  = 8'h21 + 8'(idx);
            step();
            if (last_acc) idx++;
        end
        chk("bp_accepted", idx, D);
        #1;
        chk("bp_i_ready_low", {31'd0, I_ready}, 0);
        O_ready = 1'b1;
        for (int i = 0; i < 20 && idx < 6; i++) begin
            I_data = 8'h21 + 8'(idx);
            step();
            if (last_acc) idx++;
        end
        drain("bp_drain");
        chk("bp_count", n_out - out0, 6);

        // Random valid/ready traffic with bubbles and stalls
        for (int i = 0; i < 120; i++) begin
            I_valid = 1'($urandom_range(0, 1));
            O_ready = ($urandom_range(0, 2) != 0);
            I_data  = 8'($urandom);
            step();
        end
        drain("rand_drain");

        // Tap table on a full chain (DEPTH 4) and a DEPTH 5 chain
        O_ready = 1'b0;
        for (int i = 0; i < D; i++) begin
            I_valid = 1'b1;
            I_data  = 8'hA0 + 8'(i);
            step();
        end
        I_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            c2_valid = 1'b1;
            c2_data  = 8'hB0 + 8'(i);
            #1;
            chk("c2_i_ready", {31'd0, c2_ready}, 1);
            step();
        end
        c2_valid = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (tv[i].big) c2_tap_sel = 3'(tv[i].sel);
            else           tap_sel    = 2'(tv[i].sel);
            #1;
            chk("tap_valid", {31'd0, tv[i].big ? c2_tap_valid : tap_valid}, {31'd0, tv[i].ev});
            chk("tap_data", {24'd0, tv[i].big ? c2_tap_data : tap_data}, {24'd0, tv[i].ed});
        end

        // Flush a full chain while a word is offered
        I_valid = 1'b1; I_data = 8'hEE; flush = 1'b1;
        step();
        flush = 1'b0; I_valid = 1'b0;
        #1;
        chk("flush_o_valid", {31'd0, O_valid}, 0);
        chk("flush_o_data_kept", {24'd0, O_data}, 8'hA0);
        for (int s = 0; s < D; s++) begin
            tap_sel = 2'(s);
            #1;
            chk("flush_tap_valid", {31'd0, tap_valid}, 0);
        end
        tap_sel = 2'd0;
        #1;
        chk("flush_tap_data_kept", {24'd0, tap_data}, 8'hA3);
        drain("flush_drain");

        // Snapshot of stage 1, held while the stream moves on
        O_ready = 1'b0;
        for (int i = 0; i < D; i++) begin
            I_valid = 1'b1;
            I_data  = 8'hD0 + 8'(i);
            step();
        end
        I_valid = 1'b0;
        tap_sel = 2'd1; snap_strobe = 1'b1;
        step();
        snap_strobe = 1'b0;
        chk("snap_valid", {31'd0, snap_valid}, 1);
        chk("snap_data", {24'd0, snap_data}, 8'hD2);
        O_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            I_valid = 1'b1;
            I_data  = 8'hE0 + 8'(i);
            step();
            chk("snap_hold", {24'd0, snap_data}, 8'hD2);
        end
        tap_sel = 2'd0; snap_strobe = 1'b1; flush = 1'b1;
        step();
        snap_strobe = 1'b0; flush = 1'b0;
        chk("snap_flush_prio_data", {24'd0, snap_data}, 8'hD2);
        chk("snap_flush_prio_valid", {31'd0, snap_valid}, 1);

        // Mid-stream reset discards everything
        for (int i = 0; i < 3; i++) begin
            I_data = 8'hC0 + 8'(i);
            step();
        end
        RESETN = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        exp_q.delete();
        I_valid = 1'b0;
        #1;
        chk("mrst_snap_valid", {31'd0, snap_valid}, 0);
        chk("mrst_snap_data", {24'd0, snap_data}, 0);
        chk("mrst_o_valid", {31'd0, O_valid}, 0);
        chk("mrst_i_ready", {31'd0, I_ready}, 1);
        RESETN = 1'b1;
        @(negedge CLK);
        out0 = n_out;
        for (int i = 0; i < 3; i++) begin
            I_valid = 1'b1;
            I_data  = 8'hF0 + 8'(i);
            step();
        end
        drain("post_rst_drain");
        chk("post_rst_count", n_out - out0, 3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
